rv_g_operand_fetch: RTL and testbench

RV_G_OPERAND_FETCH -- requirements
Module: rv_g_operand_fetch

---
 rtl/rv_g_operand_fetch.sv | 174 +++++++++++++++++
 tb/tb_rv_g_operand_fetch.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_g_operand_fetch.sv
// Two-slot operand fetch stage between decode and execute: slot A holds a decoded
// instruction until the register file grants, slot B holds it with captured operands.
module rv_g_operand_fetch #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned FLEN  = 32,
  parameter int unsigned UOP_W = 32
) (
  input  logic                                   clk_i,
  input  logic                                   arst_ni,
  input  logic                                   flush_i,
  // upstream decode handshake
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [UOP_W-1:0]                       in_uop_i,
  input  logic [5:0]                             in_rd_addr_i,
  input  logic [5:0]                             in_rs1_addr_i,
  input  logic [5:0]                             in_rs2_addr_i,
  input  logic [5:0]                             in_rs3_addr_i,
  // register-file request / grant
  output logic                                   rf_req_o,
  output logic [5:0]                             rf_rd_addr_o,
  output logic [5:0]                             rf_rs1_addr_o,
  output logic [5:0]                             rf_rs2_addr_o,
  output logic [5:0]                             rf_rs3_addr_o,
  input  logic                                   rf_gnt_i,
  input  logic [((XLEN > FLEN) ? XLEN : FLEN)-1:0] rf_rs1_data_i,
  input  logic [((XLEN > FLEN) ? XLEN : FLEN)-1:0] rf_rs2_data_i,
  input  logic [((XLEN > FLEN) ? XLEN : FLEN)-1:0] rf_rs3_data_i,
  // downstream execute handshake
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [UOP_W-1:0]                       out_uop_o,
  output logic [5:0]                             out_rd_addr_o,
  output logic [((XLEN > FLEN) ? XLEN : FLEN)-1:0] out_rs1_data_o,
  output logic [((XLEN > FLEN) ? XLEN : FLEN)-1:0] out_rs2_data_o,
  output logic [((XLEN > FLEN) ? XLEN : FLEN)-1:0] out_rs3_data_o,
  output logic [15:0]                            stall_cnt_o
);

  localparam int unsigned MaxLen = (XLEN > FLEN) ? XLEN : FLEN;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e       a_state_q, a_state_d;
  logic [UOP_W-1:0]  a_uop_q, a_uop_d;
  logic [5:0]        a_rd_q, a_rd_d;
  logic [5:0]        a_rs1_q, a_rs1_d;
  logic [5:0]        a_rs2_q, a_rs2_d;
  logic [5:0]        a_rs3_q, a_rs3_d;

  slot_state_e       b_state_q, b_state_d;
  logic [UOP_W-1:0]  b_uop_q, b_uop_d;
  logic [5:0]        b_rd_q, b_rd_d;
  logic [MaxLen-1:0] b_rs1_q, b_rs1_d;
  logic [MaxLen-1:0] b_rs2_q, b_rs2_d;
  logic [MaxLen-1:0] b_rs3_q, b_rs3_d;

  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic a_full, b_full;
  logic capture, load, drain;

  assign a_full = (a_state_q == SLOT_FULL);
  assign b_full = (b_state_q == SLOT_FULL);

  // A grant locks rd, so only request when slot B is certain to take the operands.
  assign rf_req_o   = a_full & ~flush_i & (~b_full | out_ready_i);
  assign capture    = rf_req_o & rf_gnt_i;
  assign in_ready_o = ~flush_i & (~a_full | capture);
  assign load       = in_valid_i & in_ready_o;
  assign drain      = b_full & out_ready_i;

  assign rf_rd_addr_o  = a_rd_q;
  assign rf_rs1_addr_o = a_rs1_q;
  assign rf_rs2_addr_o = a_rs2_q;
  assign rf_rs3_addr_o = a_rs3_q;

  assign out_valid_o    = b_full;
  assign out_uop_o      = b_uop_q;
  assign out_rd_addr_o  = b_rd_q;
  assign out_rs1_data_o = b_rs1_q;
  assign out_rs2_data_o = b_rs2_q;
  assign out_rs3_data_o = b_rs3_q;
  assign stall_cnt_o    = stall_cnt_q;

  always_comb begin
    a_state_d = a_state_q;
    a_uop_d   = a_uop_q;
    a_rd_d    = a_rd_q;
    a_rs1_d   = a_rs1_q;
    a_rs2_d   = a_rs2_q;
    a_rs3_d   = a_rs3_q;

    if (flush_i) begin
      a_state_d = SLOT_EMPTY;
    end else if (load) begin
      a_state_d = SLOT_FULL;
      a_uop_d   = in_uop_i;
      a_rd_d    = in_rd_addr_i;
      a_rs1_d   = in_rs1_addr_i;
      a_rs2_d   = in_rs2_addr_i;
      a_rs3_d   = in_rs3_addr_i;
    end else if (capture) begin
      a_state_d = SLOT_EMPTY;
    end
  end

  always_comb begin
    b_state_d = b_state_q;
    b_uop_d   = b_uop_q;
    b_rd_d    = b_rd_q;
    b_rs1_d   = b_rs1_q;
    b_rs2_d   = b_rs2_q;
    b_rs3_d   = b_rs3_q;

    if (flush_i) begin
      b_state_d = SLOT_EMPTY;
    end else if (capture) begin
      b_state_d = SLOT_FULL;
      b_uop_d   = a_uop_q;
      b_rd_d    = a_rd_q;
      b_rs1_d   = rf_rs1_data_i;
      b_rs2_d   = rf_rs2_data_i;
      b_rs3_d   = rf_rs3_data_i;
    end else if (drain) begin
      b_state_d = SLOT_EMPTY;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      stall_cnt_d = '0;
    end else if (a_full && !capture && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      a_state_q   <= SLOT_EMPTY;
      a_uop_q     <= '0;
      a_rd_q      <= '0;
      a_rs1_q     <= '0;
      a_rs2_q     <= '0;
      a_rs3_q     <= '0;
      b_state_q   <= SLOT_EMPTY;
      b_uop_q     <= '0;
      b_rd_q      <= '0;
      b_rs1_q     <= '0;
      b_rs2_q     <= '0;
      b_rs3_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      a_state_q   <= a_state_d;
      a_uop_q     <= a_uop_d;
      a_rd_q      <= a_rd_d;
      a_rs1_q     <= a_rs1_d;
      a_rs2_q     <= a_rs2_d;
      a_rs3_q     <= a_rs3_d;
      b_state_q   <= b_state_d;
      b_uop_q     <= b_uop_d;
      b_rd_q      <= b_rd_d;
      b_rs1_q     <= b_rs1_d;
      b_rs2_q     <= b_rs2_d;
      b_rs3_q     <= b_rs3_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_rv_g_operand_fetch.sv
// Bench for rv_g_operand_fetch: directed scenarios plus a randomized run against a
// queue-based transaction model of the two slots.
module tb_rv_g_operand_fetch;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned FLEN  = 32;
  localparam int unsigned UOP_W = 32;
  localparam int unsigned ML    = 64;

  logic             clk_i = 1'b0;
  logic             arst_ni;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [UOP_W-1:0] in_uop_i;
  logic [5:0]       in_rd_addr_i, in_rs1_addr_i, in_rs2_addr_i, in_rs3_addr_i;
  logic             rf_req_o;
  logic [5:0]       rf_rd_addr_o, rf_rs1_addr_o, rf_rs2_addr_o, rf_rs3_addr_o;
  logic             rf_gnt_i;
  logic [ML-1:0]    rf_rs1_data_i, rf_rs2_data_i, rf_rs3_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [UOP_W-1:0] out_uop_o;
  logic [5:0]       out_rd_addr_o;
  logic [ML-1:0]    out_rs1_data_o, out_rs2_data_o, out_rs3_data_o;
  logic [15:0]      stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  rv_g_operand_fetch #(.XLEN(XLEN), .FLEN(FLEN), .UOP_W(UOP_W)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_uop_i(in_uop_i),
    .in_rd_addr_i(in_rd_addr_i), .in_rs1_addr_i(in_rs1_addr_i),
    .in_rs2_addr_i(in_rs2_addr_i), .in_rs3_addr_i(in_rs3_addr_i),
    .rf_req_o(rf_req_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_rs1_addr_o(rf_rs1_addr_o),
    .rf_rs2_addr_o(rf_rs2_addr_o), .rf_rs3_addr_o(rf_rs3_addr_o),
    .rf_gnt_i(rf_gnt_i), .rf_rs1_data_i(rf_rs1_data_i),
    .rf_rs2_data_i(rf_rs2_data_i), .rf_rs3_data_i(rf_rs3_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_uop_o(out_uop_o),
    .out_rd_addr_o(out_rd_addr_o), .out_rs1_data_o(out_rs1_data_o),
    .out_rs2_data_o(out_rs2_data_o), .out_rs3_data_o(out_rs3_data_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic idle();
    flush_i       = 1'b0;
    in_valid_i    = 1'b0;
    in_uop_i      = '0;
    in_rd_addr_i  = '0;
    in_rs1_addr_i = '0;
    in_rs2_addr_i = '0;
    in_rs3_addr_i = '0;
    rf_gnt_i      = 1'b0;
    rf_rs1_data_i = '0;
    rf_rs2_data_i = '0;
    rf_rs3_data_i = '0;
    out_ready_i   = 1'b0;
  endtask

  task automatic drive_uop(input logic [31:0] uop, input logic [5:0] rd,
                           input logic [5:0] rs1, input logic [5:0] rs2);
    in_valid_i    = 1'b1;
    in_uop_i      = uop;
    in_rd_addr_i  = rd;
    in_rs1_addr_i = rs1;
    in_rs2_addr_i = rs2;
    in_rs3_addr_i = 6'd0;
  endtask

  // Empty both slots and zero the stall counter; inputs are left idle.
  task automatic do_flush();
    @(negedge clk_i);
    idle();
    flush_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    arst_ni = 1'b0;
    #12;
    n_checks++;
    if ({out_valid_o, rf_req_o, stall_cnt_o} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid=%b req=%b stall=%0d want 0/0/0", out_valid_o, rf_req_o, stall_cnt_o);
    end
    n_checks++;
    if ({out_uop_o, out_rd_addr_o, out_rs1_data_o, out_rs2_data_o, out_rs3_data_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: uop=%h rd=%h d1=%h want all zero", out_uop_o, out_rd_addr_o, out_rs1_data_o);
    end
    @(negedge clk_i);
    arst_ni = 1'b1;
  endtask

  task automatic test_single();
    do_flush();
    drive_uop(32'hA5A5_0001, 6'd5, 6'd1, 6'd2);
    rf_gnt_i = 1'b1; out_ready_i = 1'b1;
    rf_rs1_data_i = 64'h11; rf_rs2_data_i = 64'h22; rf_rs3_data_i = 64'h33;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    n_checks++;
    if (rf_req_o !== 1'b1 || rf_rs1_addr_o !== 6'd1 || rf_rs2_addr_o !== 6'd2 || rf_rd_addr_o !== 6'd5) begin
      n_fail++;
      $display("FAIL single_req: req=%b rd=%0d rs1=%0d rs2=%0d want 1/5/1/2", rf_req_o, rf_rd_addr_o, rf_rs1_addr_o, rf_rs2_addr_o);
    end
    n_checks++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: out_valid=%b want 0 in cycle N+1", out_valid_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (out_valid_o !== 1'b1 || out_rs1_data_o !== 64'h11 || out_rs2_data_o !== 64'h22 ||
        out_rd_addr_o !== 6'd5 || out_uop_o !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL single_out: valid=%b d1=%h d2=%h rd=%0d uop=%h want 1/11/22/5/a5a50001",
               out_valid_o, out_rs1_data_o, out_rs2_data_o, out_rd_addr_o, out_uop_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    idle();
  endtask

  task automatic test_back_to_back();
    int got_uop[$];
    int got_cyc[$];
    int ready_bad = 0;
    do_flush();
    rf_gnt_i = 1'b1; out_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive_uop(32'(c + 1), 6'(c + 8), 6'(c + 1), 6'(c + 2));
      else in_valid_i = 1'b0;
      rf_rs1_data_i = 64'(c) * 64'h100;
      #1;
      if (c < 4 && in_ready_o !== 1'b1) ready_bad++;
      if (out_valid_o === 1'b1) begin
        got_uop.push_back(int'(out_uop_o));
        got_cyc.push_back(c);
      end
      @(posedge clk_i);
      @(negedge clk_i);
    end
    n_checks++;
    if (ready_bad != 0) begin
      n_fail++;
      $display("FAIL b2b_ready: in_ready low in %0d of 4 cycles want 0", ready_bad);
    end
    n_checks++;
    if (got_uop.size() != 4 || got_uop[0] != 1 || got_uop[1] != 2 || got_uop[2] != 3 || got_uop[3] != 4) begin
      n_fail++;
      $display("FAIL b2b_order: got %0d outputs %p want 1,2,3,4", got_uop.size(), got_uop);
    end
    n_checks++;
    if (got_cyc.size() != 4 || got_cyc[0] != 2 || got_cyc[3] != 5) begin
      n_fail++;
      $display("FAIL b2b_timing: cycles %p want 2,3,4,5", got_cyc);
    end
    idle();
  endtask

  task automatic test_stall();
    int bad = 0;
    do_flush();
    drive_uop(32'hBEEF, 6'd7, 6'd3, 6'd4);
    rf_gnt_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (in_ready_o !== 1'b0 || rf_rs1_addr_o !== 6'd3 || rf_rd_addr_o !== 6'd7 || out_valid_o !== 1'b0) bad++;
      @(posedge clk_i);
      @(negedge clk_i);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d bad cycles want 0", bad);
    end
    n_checks++;
    if (stall_cnt_o !== 16'd10) begin
      n_fail++;
      $display("FAIL stall_count: got %0d want 10", stall_cnt_o);
    end
    rf_gnt_i = 1'b1;
    rf_rs1_data_i = 64'hDEAD_BEEF_0000_0001;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_grant_ready: in_ready=%b want 1", in_ready_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rf_gnt_i = 1'b0;
    n_checks++;
    if (out_valid_o !== 1'b1 || out_uop_o !== 32'hBEEF || out_rs1_data_o !== 64'hDEAD_BEEF_0000_0001 || stall_cnt_o !== 16'd10) begin
      n_fail++;
      $display("FAIL stall_capture: valid=%b uop=%h d1=%h stall=%0d want 1/beef/deadbeef00000001/10",
               out_valid_o, out_uop_o, out_rs1_data_o, stall_cnt_o);
    end
    idle();
  endtask

  // Leaves slot B holding uop 0x100 and slot A holding uop 0x200.
  task automatic fill_both();
    do_flush();
    out_ready_i = 1'b0; rf_gnt_i = 1'b1;
    drive_uop(32'h100, 6'd10, 6'd1, 6'd2);
    rf_rs1_data_i = 64'hAAAA; rf_rs2_data_i = 64'hBBBB;
    @(posedge clk_i);
    @(negedge clk_i);
    drive_uop(32'h200, 6'd11, 6'd3, 6'd4);
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    rf_rs1_data_i = 64'hCCCC; rf_rs2_data_i = 64'hDDDD;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    fill_both();
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rf_req_o !== 1'b0 || out_valid_o !== 1'b1 || out_uop_o !== 32'h100 || out_rs1_data_o !== 64'hAAAA) bad++;
      @(posedge clk_i);
      @(negedge clk_i);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d cycles with req/out wrong want 0 (uop=%h)", bad, out_uop_o);
    end
    out_ready_i = 1'b1;
    #1;
    n_checks++;
    if (rf_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_req: req=%b want 1", rf_req_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    n_checks++;
    if (out_valid_o !== 1'b1 || out_uop_o !== 32'h200 || out_rs1_data_o !== 64'hCCCC || out_rd_addr_o !== 6'd11) begin
      n_fail++;
      $display("FAIL bp_refill: valid=%b uop=%h d1=%h rd=%0d want 1/200/cccc/11", out_valid_o, out_uop_o, out_rs1_data_o, out_rd_addr_o);
    end
    idle();
  endtask

  task automatic test_flush();
    fill_both();
    out_ready_i = 1'b1;
    flush_i = 1'b1;
    drive_uop(32'h300, 6'd12, 6'd5, 6'd6);
    #1;
    n_checks++;
    if (rf_req_o !== 1'b0 || in_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: req=%b in_ready=%b want 0/0", rf_req_o, in_ready_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    idle();
    #1;
    n_checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || stall_cnt_o !== 16'd0 || rf_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: valid=%b in_ready=%b stall=%0d req=%b want 0/1/0/0", out_valid_o, in_ready_o, stall_cnt_o, rf_req_o);
    end
  endtask

  typedef struct {
    logic [31:0] uop;
    logic [5:0]  rd, rs1, rs2, rs3;
  } instr_t;
  typedef struct {
    logic [31:0] uop;
    logic [5:0]  rd;
    logic [63:0] d1, d2, d3;
  } result_t;

  task automatic test_random();
    instr_t  pend[$];
    result_t done[$];
    int      stall = 0;
    int      bad = 0;
    int      outs = 0;
    logic    e_req, e_cap, e_rdy;
    instr_t  ni;
    result_t nr;
    do_flush();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      flush_i       = ($urandom_range(0, 39) == 0);
      in_valid_i    = ($urandom_range(0, 3) != 0);
      in_uop_i      = $urandom;
      in_rd_addr_i  = 6'($urandom);
      in_rs1_addr_i = 6'($urandom);
      in_rs2_addr_i = 6'($urandom);
      in_rs3_addr_i = 6'($urandom);
      rf_gnt_i      = ($urandom_range(0, 2) != 0);
      out_ready_i   = ($urandom_range(0, 2) != 0);
      rf_rs1_data_i = {$urandom, $urandom};
      rf_rs2_data_i = {$urandom, $urandom};
      rf_rs3_data_i = {$urandom, $urandom};
      #1;
      e_req = (pend.size() != 0) && !flush_i && (done.size() == 0 || out_ready_i);
      e_cap = e_req && rf_gnt_i;
      e_rdy = !flush_i && (pend.size() == 0 || e_cap);
      n_checks++;
      if (rf_req_o !== e_req || in_ready_o !== e_rdy || out_valid_o !== (done.size() != 0) || stall_cnt_o !== 16'(stall)) begin
        n_fail++; bad++;
        if (bad < 6)
          $display("FAIL rand_ctrl cyc %0d: req=%b rdy=%b vld=%b stall=%0d want %b/%b/%b/%0d",
                   cyc, rf_req_o, in_ready_o, out_valid_o, stall_cnt_o, e_req, e_rdy, done.size() != 0, stall);
      end
      if (pend.size() != 0) begin
        n_checks++;
        if (rf_rd_addr_o !== pend[0].rd || rf_rs1_addr_o !== pend[0].rs1 ||
            rf_rs2_addr_o !== pend[0].rs2 || rf_rs3_addr_o !== pend[0].rs3) begin
          n_fail++; bad++;
          if (bad < 6) $display("FAIL rand_addr cyc %0d: rs1=%0d want %0d", cyc, rf_rs1_addr_o, pend[0].rs1);
        end
      end
      if (done.size() != 0) begin
        n_checks++;
        if (out_uop_o !== done[0].uop || out_rd_addr_o !== done[0].rd || out_rs1_data_o !== done[0].d1 ||
            out_rs2_data_o !== done[0].d2 || out_rs3_data_o !== done[0].d3) begin
          n_fail++; bad++;
          if (bad < 6) $display("FAIL rand_data cyc %0d: uop=%h d1=%h want %h/%h", cyc, out_uop_o, out_rs1_data_o, done[0].uop, done[0].d1);
        end
      end
      @(posedge clk_i);
      if (flush_i) begin
        pend.delete(); done.delete(); stall = 0;
      end else begin
        if (pend.size() != 0 && !e_cap && stall < 65535) stall++;
        if (done.size() != 0 && out_ready_i) begin
          void'(done.pop_front());
          outs++;
        end
        if (e_cap) begin
          ni = pend.pop_front();
          nr.uop = ni.uop; nr.rd = ni.rd;
          nr.d1 = rf_rs1_data_i; nr.d2 = rf_rs2_data_i; nr.d3 = rf_rs3_data_i;
          done.push_back(nr);
        end
        if (in_valid_i && e_rdy) begin
          ni.uop = in_uop_i; ni.rd = in_rd_addr_i; ni.rs1 = in_rs1_addr_i;
          ni.rs2 = in_rs2_addr_i; ni.rs3 = in_rs3_addr_i;
          pend.push_back(ni);
        end
      end
      @(negedge clk_i);
    end
    n_checks++;
    if (outs < 100) begin
      n_fail++;
      $display("FAIL rand_progress: only %0d outputs drained want >= 100", outs);
    end
    idle();
  endtask

  task automatic test_saturation();
    fill_both();
    rf_gnt_i = 1'b0;
    repeat (70000) @(negedge clk_i);
    #1;
    n_checks++;
    if (stall_cnt_o !== 16'hFFFF || out_uop_o !== 32'h100 || out_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_value: stall=%h uop=%h valid=%b want ffff/100/1", stall_cnt_o, out_uop_o, out_valid_o);
    end
    @(posedge clk_i);
    #3;
    arst_ni = 1'b0;
    #1;
    n_checks++;
    if ({out_valid_o, rf_req_o, stall_cnt_o, out_uop_o, out_rd_addr_o, out_rs1_data_o, out_rs2_data_o, out_rs3_data_o} !== '0) begin
      n_fail++;
      $display("FAIL sat_async_reset: valid=%b req=%b stall=%h uop=%h d1=%h want all zero",
               out_valid_o, rf_req_o, stall_cnt_o, out_uop_o, out_rs1_data_o);
    end
    @(negedge clk_i);
    idle();
    arst_ni = 1'b1;
    drive_uop(32'h400, 6'd13, 6'd9, 6'd10);
    rf_gnt_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    n_checks++;
    if (rf_req_o !== 1'b1 || rf_rs1_addr_o !== 6'd9 || out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_accept: req=%b rs1=%0d valid=%b want 1/9/0", rf_req_o, rf_rs1_addr_o, out_valid_o);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_backpressure();
    test_flush();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
